// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/function encodings, control-bit positions and the op/func decoder.
package decode_pkg;

    localparam int CTL_W = 8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Bit positions inside the control vector {regwrite,memread,memwrite,memtoreg,branch,jr,alusrc,zext}
    localparam int CTL_REGWRITE = 7;
    localparam int CTL_MEMREAD  = 6;
    localparam int CTL_MEMWRITE = 5;
    localparam int CTL_MEMTOREG = 4;
    localparam int CTL_BRANCH   = 3;
    localparam int CTL_JR       = 2;
    localparam int CTL_ALUSRC   = 1;
    localparam int CTL_ZEXT     = 0;

    typedef struct packed {
        logic             regdst;
        logic [CTL_W-1:0] ctl;
    } dec_t;

    function automatic dec_t decode_op(input logic [5:0] op, input logic [5:0] func);
        dec_t d;
        d.regdst = 1'b0;
        d.ctl    = {CTL_W{1'b0}};
        case (op)
            OP_RTYPE: begin
                d.regdst = 1'b1;
                if (func == FN_JR) begin
                    d.ctl[CTL_JR] = 1'b1;
                end else begin
                    d.ctl[CTL_REGWRITE] = 1'b1;
                end
            end
            OP_LW: begin
                d.ctl[CTL_REGWRITE] = 1'b1;
                d.ctl[CTL_MEMREAD]  = 1'b1;
                d.ctl[CTL_MEMTOREG] = 1'b1;
                d.ctl[CTL_ALUSRC]   = 1'b1;
            end
            OP_SW: begin
                d.ctl[CTL_MEMWRITE] = 1'b1;
                d.ctl[CTL_ALUSRC]   = 1'b1;
            end
            OP_BEQ: begin
                d.ctl[CTL_BRANCH] = 1'b1;
            end
            OP_ADDI: begin
                d.ctl[CTL_REGWRITE] = 1'b1;
                d.ctl[CTL_ALUSRC]   = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                d.ctl[CTL_REGWRITE] = 1'b1;
                d.ctl[CTL_ALUSRC]   = 1'b1;
                d.ctl[CTL_ZEXT]     = 1'b1;
            end
            default: begin
                d.regdst = 1'b0;
                d.ctl    = {CTL_W{1'b0}};
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file with two combinational read ports and one clocked write port; r0 is hard-wired to zero.
// DECODE_WB_BYPASS_EN: a read of the index being written this cycle returns the write data.
module decode_regfile #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = $clog2(REG_NUM)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_ra_addr,
    input  logic [ADDR_W-1:0] i_rb_addr,
    output logic [DATA_W-1:0] o_ra_data,
    output logic [DATA_W-1:0] o_rb_data,
    input  logic              i_wb_en,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data
);

    logic [DATA_W-1:0] r_regs [REG_NUM];
    logic              w_wb_live;

    assign w_wb_live = i_wb_en && (i_wb_addr != {ADDR_W{1'b0}});

    // Write port; writes to r0 are discarded
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_regs <= '{default: {DATA_W{1'b0}}};
        end else if (w_wb_live) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    // Read port A
    always_comb begin
        o_ra_data = r_regs[i_ra_addr];
`ifdef DECODE_WB_BYPASS_EN
        if (w_wb_live && (i_wb_addr == i_ra_addr)) begin
            o_ra_data = i_wb_data;
        end else begin
            o_ra_data = r_regs[i_ra_addr];
        end
`endif
        if (i_ra_addr == {ADDR_W{1'b0}}) begin
            o_ra_data = {DATA_W{1'b0}};
        end else begin
            o_ra_data = o_ra_data;
        end
    end

    // Read port B
    always_comb begin
        o_rb_data = r_regs[i_rb_addr];
`ifdef DECODE_WB_BYPASS_EN
        if (w_wb_live && (i_wb_addr == i_rb_addr)) begin
            o_rb_data = i_wb_data;
        end else begin
            o_rb_data = r_regs[i_rb_addr];
        end
`endif
        if (i_rb_addr == {ADDR_W{1'b0}}) begin
            o_rb_data = {DATA_W{1'b0}};
        end else begin
            o_rb_data = o_rb_data;
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Pipelined decode stage: register read, control decode, immediate extension, load-use hazard and ID/EX register.
// DECODE_WB_BYPASS_EN selects same-cycle write-back forwarding; without it, decode stalls on a pending write-back.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int REG_NUM = 32,
    localparam int ADDR_W  = $clog2(REG_NUM)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [5:0]        i_op,
    input  logic [5:0]        i_func,
    input  logic [ADDR_W-1:0] i_rs,
    input  logic [ADDR_W-1:0] i_rt,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [15:0]       i_imm,
    input  logic              i_flush,
    input  logic              i_wb_en,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [DATA_W-1:0] o_rt_data,
    output logic [DATA_W-1:0] o_ext_imm,
    output logic [ADDR_W-1:0] o_rw_out,
    output logic [CTL_W-1:0]  o_ctl_out
);

    localparam int PAD_W = DATA_W - 16;

    logic              r_valid;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_ext_imm;
    logic [ADDR_W-1:0] r_rw;
    logic [CTL_W-1:0]  r_ctl;

    dec_t              w_dec;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] w_alu_b;
    logic [ADDR_W-1:0] w_rw;
    logic              w_load_use;
    logic              w_wb_pending;
    logic              w_hz;
    logic              w_in_ready;

    decode_regfile #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W)
    ) u_regfile (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_ra_addr (i_rs),
        .i_rb_addr (i_rt),
        .o_ra_data (w_rs_val),
        .o_rb_data (w_rt_val),
        .i_wb_en   (i_wb_en),
        .i_wb_addr (i_wb_addr),
        .i_wb_data (i_wb_data)
    );

    // Control decode, immediate extension and operand/destination selection
    always_comb begin
        w_dec = decode_op(i_op, i_func);
        if (w_dec.ctl[CTL_ZEXT]) begin
            w_ext = {{PAD_W{1'b0}}, i_imm};
        end else begin
            w_ext = {{PAD_W{i_imm[15]}}, i_imm};
        end
        if (w_dec.ctl[CTL_ALUSRC]) begin
            w_alu_b = w_ext;
        end else begin
            w_alu_b = w_rt_val;
        end
        if (w_dec.regdst) begin
            w_rw = i_rd;
        end else begin
            w_rw = i_rt;
        end
    end

    // Hazard detection: load in ID/EX feeding a source here, plus unforwarded write-back when no bypass
    always_comb begin
        w_load_use = r_valid && r_ctl[CTL_MEMREAD] && (r_rw != {ADDR_W{1'b0}}) &&
                     ((r_rw == i_rs) || ((r_rw == i_rt) && !w_dec.ctl[CTL_ALUSRC]));
`ifdef DECODE_WB_BYPASS_EN
        w_wb_pending = 1'b0;
`else
        w_wb_pending = i_wb_en && (i_wb_addr != {ADDR_W{1'b0}}) &&
                       ((i_wb_addr == i_rs) || (i_wb_addr == i_rt));
`endif
        w_hz       = w_load_use || w_wb_pending;
        w_in_ready = (!r_valid || i_out_ready) && !w_hz;
    end

    // ID/EX register: reset > flush > hazard bubble > advance/drain/hold
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid   <= 1'b0;
            r_alu_a   <= {DATA_W{1'b0}};
            r_alu_b   <= {DATA_W{1'b0}};
            r_rt_data <= {DATA_W{1'b0}};
            r_ext_imm <= {DATA_W{1'b0}};
            r_rw      <= {ADDR_W{1'b0}};
            r_ctl     <= {CTL_W{1'b0}};
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_hz && i_out_ready) begin
            r_valid <= 1'b0;
        end else if (i_in_valid && w_in_ready) begin
            r_valid   <= 1'b1;
            r_alu_a   <= w_rs_val;
            r_alu_b   <= w_alu_b;
            r_rt_data <= w_rt_val;
            r_ext_imm <= w_ext;
            r_rw      <= w_rw;
            r_ctl     <= w_dec.ctl;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_valid;
    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_rt_data   = r_rt_data;
    assign o_ext_imm   = r_ext_imm;
    assign o_rw_out    = r_rw;
    assign o_ctl_out   = r_ctl;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed scenarios plus randomized traffic against a reference model.
module tb_decode_stage_pipe;

`ifdef DECODE_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a, alu_b, rt_data, ext_imm;
    logic [4:0]  rw_out;
    logic [7:0]  ctl_out;

    int checks = 0;
    int errors = 0;

    decode_stage_pipe dut (
        .i_clock(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op(op), .i_func(func), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_imm(imm),
        .i_flush(flush), .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_rt_data(rt_data), .o_ext_imm(ext_imm),
        .o_rw_out(rw_out), .o_ctl_out(ctl_out)
    );

    always #5 clk = ~clk;

    // Reference decode table: {regdst, regwrite,memread,memwrite,memtoreg,branch,jr,alusrc,zext}
    function automatic logic [8:0] ref_decode(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00:        return (f == 6'h08) ? 9'h104 : 9'h180;
            6'h23:        return 9'h0D2;
            6'h2B:        return 9'h022;
            6'h04:        return 9'h008;
            6'h08:        return 9'h082;
            6'h0C, 6'h0D: return 9'h083;
            default:      return 9'h000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; op = 6'h00; func = 6'h00; rs = 5'd0; rt = 5'd0; rd = 5'd0;
        imm = 16'h0000; flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        out_ready = 1'b1;
    endtask

    task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic [15:0] im);
        in_valid = 1'b1; op = o; func = f; rs = s; rt = t; rd = d; imm = im;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b exp 0", out_valid);
        end
        checks++;
        if ({alu_a, alu_b, rt_data, ext_imm, rw_out, ctl_out} !== 141'd0) begin
            errors++; $display("FAIL reset_fields got %h %h %h %h %h %h exp all 0",
                               alu_a, alu_b, rt_data, ext_imm, rw_out, ctl_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        tick();
    endtask

    task automatic test_addi();
        idle();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        tick();
        idle();
        instr(6'h08, 6'h00, 5'd5, 5'd6, 5'd0, 16'hFFFF);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({out_valid, alu_a, alu_b, ext_imm, rw_out, ctl_out} !==
            {1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 8'h82}) begin
            errors++; $display("FAIL addi got v=%b a=%h b=%h e=%h rw=%0d ctl=%h exp v=1 a=00001234 b=ffffffff e=ffffffff rw=6 ctl=82",
                               out_valid, alu_a, alu_b, ext_imm, rw_out, ctl_out);
        end
        tick();
    endtask

    task automatic test_ori_r0();
        idle();
        instr(6'h0D, 6'h00, 5'd0, 5'd3, 5'd0, 16'h8000);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({out_valid, ext_imm, alu_b, alu_a, ctl_out} !== {1'b1, 32'h0000_8000, 32'h0000_8000, 32'h0, 8'h83}) begin
            errors++; $display("FAIL ori_zext got v=%b e=%h b=%h a=%h ctl=%h exp v=1 e=00008000 b=00008000 a=0 ctl=83",
                               out_valid, ext_imm, alu_b, alu_a, ctl_out);
        end
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        tick();
        idle();
        instr(6'h00, 6'h20, 5'd0, 5'd0, 5'd4, 16'h0000);
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({out_valid, alu_a, rt_data, rw_out, ctl_out} !== {1'b1, 32'h0, 32'h0, 5'd4, 8'h80}) begin
            errors++; $display("FAIL r0_read got v=%b a=%h rt=%h rw=%0d ctl=%h exp v=1 a=0 rt=0 rw=4 ctl=80",
                               out_valid, alu_a, rt_data, rw_out, ctl_out);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        instr(6'h23, 6'h00, 5'd1, 5'd7, 5'd0, 16'h0004);
        tick();
        instr(6'h00, 6'h20, 5'd7, 5'd2, 5'd8, 16'h0000);
        @(negedge clk);
        checks++;
        if ({out_valid, ctl_out, rw_out, in_ready} !== {1'b1, 8'hD2, 5'd7, 1'b0}) begin
            errors++; $display("FAIL load_use_stall got v=%b ctl=%h rw=%0d rdy=%b exp v=1 ctl=d2 rw=7 rdy=0",
                               out_valid, ctl_out, rw_out, in_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL load_use_bubble got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if ({out_valid, rw_out, ctl_out} !== {1'b1, 5'd8, 8'h80}) begin
            errors++; $display("FAIL load_use_issue got v=%b rw=%0d ctl=%h exp v=1 rw=8 ctl=80",
                               out_valid, rw_out, ctl_out);
        end
        tick();
    endtask

    task automatic test_backpressure_flush();
        idle();
        out_ready = 1'b0;
        instr(6'h0D, 6'h00, 5'd1, 5'd3, 5'd0, 16'h1111);
        tick();
        instr(6'h08, 6'h00, 5'd2, 5'd4, 5'd0, 16'h2222);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, ext_imm, rw_out, in_ready} !== {1'b1, 32'h0000_1111, 5'd3, 1'b0}) begin
                errors++; $display("FAIL backpressure_hold%0d got v=%b e=%h rw=%0d rdy=%b exp v=1 e=00001111 rw=3 rdy=0",
                                   c, out_valid, ext_imm, rw_out, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_kill got v=%b exp 0", out_valid);
        end
        idle();
        tick();
    endtask

    task automatic test_wb_overlap();
        idle();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_00AA;
        instr(6'h08, 6'h00, 5'd9, 5'd10, 5'd0, 16'h0001);
`ifdef DECODE_WB_BYPASS_EN
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL wb_bypass_ready got %b exp 1", in_ready);
        end
        tick();
`else
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL wb_stall_ready got %b exp 0", in_ready);
        end
        tick();
        wb_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL wb_stall_bubble got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        end
        tick();
`endif
        idle();
        @(negedge clk);
        checks++;
        if ({out_valid, alu_a, rw_out} !== {1'b1, 32'h0000_00AA, 5'd10}) begin
            errors++; $display("FAIL wb_overlap_result got v=%b a=%h rw=%0d exp v=1 a=000000aa rw=10",
                               out_valid, alu_a, rw_out);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] regs [32];
        logic        mv;
        logic [31:0] ma, mb, mrt, mext;
        logic [4:0]  mrw;
        logic [7:0]  mctl;
        logic [8:0]  dec;
        logic        hz, rdy;
        logic [31:0] rsv, rtv, ext;
        logic [5:0]  ops [8];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h00};
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        mv = 1'b0; ma = 32'h0; mb = 32'h0; mrt = 32'h0; mext = 32'h0; mrw = 5'd0; mctl = 8'h0;
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            func      = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            rs        = 5'($urandom_range(0, 7));
            rt        = 5'($urandom_range(0, 7));
            rd        = 5'($urandom_range(0, 7));
            imm       = 16'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = ($urandom_range(0, 2) == 0);
            wb_addr   = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            dec = ref_decode(op, func);
            hz  = mv && mctl[6] && (mrw != 5'd0) && ((mrw == rs) || ((mrw == rt) && !dec[1]));
            if (!BYPASS && wb_en && (wb_addr != 5'd0) && ((wb_addr == rs) || (wb_addr == rt))) hz = 1'b1;
            rdy = (!mv || out_ready) && !hz;
            checks++;
            if (in_ready !== rdy) begin
                errors++; $display("FAIL rand_in_ready cyc %0d got %b exp %b", n, in_ready, rdy);
            end
            checks++;
            if (out_valid !== mv) begin
                errors++; $display("FAIL rand_out_valid cyc %0d got %b exp %b", n, out_valid, mv);
            end
            if (mv) begin
                checks++;
                if ({alu_a, alu_b, rt_data, ext_imm, rw_out, ctl_out} !== {ma, mb, mrt, mext, mrw, mctl}) begin
                    errors++; $display("FAIL rand_bundle cyc %0d got %h %h %h %h %0d %h exp %h %h %h %h %0d %h", n,
                                       alu_a, alu_b, rt_data, ext_imm, rw_out, ctl_out, ma, mb, mrt, mext, mrw, mctl);
                end
            end
            rsv = (rs == 5'd0) ? 32'h0 : (BYPASS && wb_en && wb_addr == rs) ? wb_data : regs[rs];
            rtv = (rt == 5'd0) ? 32'h0 : (BYPASS && wb_en && wb_addr == rt) ? wb_data : regs[rt];
            ext = dec[0] ? {16'h0000, imm} : {{16{imm[15]}}, imm};
            if (flush) mv = 1'b0;
            else if (hz && out_ready) mv = 1'b0;
            else if (in_valid && rdy) begin
                mv = 1'b1; ma = rsv; mb = dec[1] ? ext : rtv; mrt = rtv; mext = ext;
                mrw = dec[8] ? rd : rt; mctl = dec[7:0];
            end
            else if (out_ready) mv = 1'b0;
            if (wb_en && wb_addr != 5'd0) regs[wb_addr] = wb_data;
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_addi();
        test_ori_r0();
        test_load_use();
        test_backpressure_flush();
        test_wb_overlap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
